// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 divider.
// Holds the FSM state enum, operand width and step-counter width.
package div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Conditional two's-complement negate: magnitude or sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(
    input logic            neg,
    input logic [XLEN-1:0] v
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring radix-2 step: trial subtract, keep or restore.
// Ports: rem/msb/dvs in; rem_nxt and quotient bit q_bit out.
module div_radix2_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic            msb,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);

  logic [XLEN:0] trial;

  assign trial = {rem, msb} - {1'b0, dvs};
  assign q_bit = ~trial[XLEN];
  // A negative trial implies {rem,msb} < dvs, so the shift fits 32 bits.
  assign rem_nxt = q_bit ? trial[XLEN-1:0]
                         : {rem[XLEN-2:0], msb};

endmodule

// File: rtl/div_radix2.sv
// Iterative 32-bit signed/unsigned restoring divider, 34-cycle latency.
// Ports: clk, reset, div, div_signed, x, y, exception -> s, r, complete.
// DIV_EARLY_EXIT_EN: finish at once with s=0, r=x when |x| < |y|.
module div_radix2
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            div,
  input  logic            div_signed,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            exception,
  output logic [XLEN-1:0] s,
  output logic [XLEN-1:0] r,
  output logic            complete
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  dvd;
  logic [XLEN-1:0]  dvs;
  logic             sign_q;
  logic             sign_r;

  logic             sx;
  logic             sy;
  logic [XLEN-1:0]  ax;
  logic [XLEN-1:0]  ay;
  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  q_nxt;
  logic             q_bit;
  logic             early;

  assign sx = div_signed & x[XLEN-1];
  assign sy = div_signed & y[XLEN-1];
  assign ax = neg_if(sx, x);
  assign ay = neg_if(sy, y);

  div_radix2_step u_step (
    .rem     (rem),
    .msb     (dvd[XLEN-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // Dividend shifts out the top while quotient bits fill the bottom.
  assign q_nxt = {dvd[XLEN-2:0], q_bit};

`ifdef DIV_EARLY_EXIT_EN
  assign early = ax < ay;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      s        <= '0;
      r        <= '0;
      complete <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (exception) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (div) begin
              cnt    <= '0;
              rem    <= '0;
              dvd    <= ax;
              dvs    <= ay;
              sign_q <= sx ^ sy;
              sign_r <= sx;
              if (early) begin
                s        <= '0;
                r        <= x;
                complete <= 1'b1;
                state    <= DONE;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            rem <= rem_nxt;
            dvd <= q_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN-1)) begin
              s        <= neg_if(sign_q, q_nxt);
              r        <= neg_if(sign_r, rem_nxt);
              complete <= 1'b1;
              state    <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative 32-bit signed/unsigned divider that responds to the ALU's divide request handshake. The ALU holds a level request until this block pulses completion, then reads quotient and remainder into HI/LO. It uses a restoring radix-2 algorithm: one quotient bit per cycle, sign-magnitude pre- and post-correction, and abort on pipeline exception.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `div`  in  1: request level, high from issue until the cycle after `complete`.
- `div_signed`  in  1: 1 = DIV (two's complement), 0 = DIVU. Sampled at start.
- `x`  in  32: dividend. Sampled at start.
- `y`  in  32: divisor. Sampled at start.
- `exception`  in  1: flush. Aborts any operation in progress.
- `s`  out  32: quotient.
- `r`  out  32: remainder.
- `complete`  out  1: one-cycle pulse; `s`/`r` are valid in that cycle.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If `div` && !`exception`: latch |x|, |y| (unsigned if !`div_signed`), sign_q = sx^sy, sign_r = sx, counter = 0. Go to RUN.
  - Otherwise stay in IDLE.
- RUN, one step per cycle:
  - Form 33-bit trial = {rem[31:0], dividend_msb} − {1'b0, |y|}.
  - If non-negative: rem = trial and the quotient bit is 1. Otherwise shift only and the quotient bit is 0.
  - Quotient bits shift in from the LSB.
  - After step 31 (counter == 31), load `s` = sign_q ? −q : q and `r` = sign_r ? −rem : rem. Go to DONE.
- DONE: `complete` = 1. Go to IDLE unconditionally. A `div` still high in the next IDLE cycle starts a new operation.
- `exception` high in any state: next state IDLE, counter cleared, `complete` stays 0, `s`/`r` unchanged. Exception has priority over start.
- `s`/`r` are registers. They hold the last result until the next RUN→DONE load.
- Divide by zero has no special case and the same latency. Restoring yields q = 0xFFFFFFFF and rem = |x|, then sign correction applies:
  - unsigned 5/0 → s = 0xFFFFFFFF, r = 5
  - signed −5/0 → s = 1, r = 0xFFFFFFFB
- Signed 0x80000000 / 0xFFFFFFFF: |x| = 0x80000000 as unsigned. Result s = 0x80000000, r = 0, with no trap.
- Remainder sign always follows the dividend; quotient truncates toward zero.

## Timing
- Reset values: state IDLE, `s` = 0, `r` = 0, `complete` = 0, counter = 0.
- `reset` overrides `exception` and `div`.
- Start accepted at the edge ending cycle N (IDLE, `div` = 1). RUN occupies cycles N+1..N+32. `complete` is high in cycle N+33 only.
- `complete` is decoded from state DONE; it does not depend combinationally on inputs.
- `x`, `y`, `div_signed` are ignored after the start edge.
- Reset mid-RUN: IDLE next cycle, `s` = `r` = 0, no `complete`.
- Exception in the DONE cycle: `complete` is still high that cycle (already committed). The ALU is responsible for discarding it.

## Configuration
- `DIV_EARLY_EXIT_EN` defined:
  - In IDLE at start, if |x| < |y| (unsigned compare of magnitudes), load s = 0 and r = x, then go directly to DONE.
  - `complete` is then high in cycle N+1.
  - y = 0 never takes this path.
- `DIV_EARLY_EXIT_EN` undefined: fixed 34-cycle latency for all operands; the comparator is not built.

## Structure
- Shared package `div_pkg`: state enum (IDLE/RUN/DONE), `XLEN` = 32, counter width 5.
- Sub-module `div_radix2_step`: combinational single step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
- Top level holds the FSM, counter, magnitude/sign-fix logic, and output registers.

## Test plan
- Unsigned 100/7, `div_signed` = 0 → s = 14, r = 2; `complete` exactly one cycle at N+33.
- Signed −7/2 → s = 0xFFFFFFFD, r = 0xFFFFFFFF.
- Signed 7/−2 → s = 0xFFFFFFFD, r = 1.
- Signed 0x80000000/0xFFFFFFFF → s = 0x80000000, r = 0.
- Unsigned 5/0 → s = 0xFFFFFFFF, r = 5.
- Signed −5/0 → s = 1, r = 0xFFFFFFFB.
- `exception` pulsed at RUN cycle 10 → no `complete`, `s`/`r` hold the previous result. A following start with 9/3 → s = 3, r = 0 at full latency.
- `reset` mid-RUN → `s` = `r` = 0, no `complete`.
- With `DIV_EARLY_EXIT_EN`: unsigned 3/10 → s = 0, r = 3 with `complete` at N+1. Then 10/3 → s = 3, r = 1 at N+33.
